// File: rtl/line_decoder_arbiter.sv
// Round-robin arbiter owning the select/enable of a shared 3-to-8 line decoder.
// Optional hold-timeout feature: define LINE_DECODER_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; Grant=0, Dec_En=0, Sel keeps last owner
// GRANT | owner latched in Sel; Dec_En=1; Grant one-hot for Sel
module line_decoder_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [7:0] Req,
  input  logic       Release,
  output logic [2:0] Sel,
  output logic       Dec_En,
  output logic [7:0] Grant,
  output logic       Timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("line_decoder_arbiter: MAX_HOLD must be within 1..255");
  end

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;
  logic [2:0] winner;
  logic [2:0] idx;
  logic       found;
  logic       owner_req;
  logic       exit_evt;
  logic       expire;

`ifdef LINE_DECODER_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
`endif

  // Requester n sits on Req[7-n]; walk from the pointer, first set bit wins.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && Req[3'd7 - idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign owner_req = Req[3'd7 - sel_q];
  assign exit_evt  = Release || !owner_req || !Enable;

`ifdef LINE_DECODER_ARB_TIMEOUT_EN
  assign expire = ({1'b0, hold_q} + 9'd1) == 9'(MAX_HOLD);
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
`ifdef LINE_DECODER_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (Enable && found) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = 8'h80 >> winner;
`ifdef LINE_DECODER_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
`ifdef LINE_DECODER_ARB_TIMEOUT_EN
        hold_d = hold_q + 8'd1;
`endif
        if (exit_evt || expire) begin
          state_d   = IDLE;
          ptr_d     = sel_q + 3'd1;
          grant_d   = '0;
          // Timeout only reports revocations nothing else would have caused.
          timeout_d = expire && !exit_evt;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
`ifdef LINE_DECODER_ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
`ifdef LINE_DECODER_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign Sel     = sel_q;
  assign Dec_En  = (state_q == GRANT);
  assign Grant   = grant_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_line_decoder_arbiter.sv
// Bench for line_decoder_arbiter: per-cycle reference model plus directed literal checks.
module tb_line_decoder_arbiter;

  localparam int MH = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic [7:0] Req = 8'h00;
  logic       Release = 1'b0;
  logic [2:0] Sel;
  logic       Dec_En;
  logic [7:0] Grant;
  logic       Timeout;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  line_decoder_arbiter #(.MAX_HOLD(MH)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Req(Req), .Release(Release),
    .Sel(Sel), .Dec_En(Dec_En), .Grant(Grant), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  // Reference model: who owns the decoder, whose turn is next, how long held.
  bit m_busy = 1'b0;
  bit m_to = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_hold = 0;

  always @(posedge Clock) begin
    bit rel, tmo;
    if (Reset) begin
      m_busy = 1'b0; m_to = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0;
    end else begin
      m_to = 1'b0;
      if (m_busy) begin
        m_hold = m_hold + 1;
        rel = Release || !Req[7 - m_owner] || !Enable;
`ifdef LINE_DECODER_ARB_TIMEOUT_EN
        tmo = (m_hold == MH);
`else
        tmo = 1'b0;
`endif
        if (rel || tmo) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % 8;
          m_to   = tmo && !rel;
        end
      end else if (Enable && Req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (!m_busy && Req[7 - ((m_ptr + k) % 8)]) begin
            m_owner = (m_ptr + k) % 8;
            m_busy  = 1'b1;
            m_hold  = 0;
          end
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("model_dec_en", 32'(Dec_En), 32'(m_busy));
      check("model_grant", 32'(Grant), m_busy ? 32'(8'h80 >> m_owner) : 32'h0);
      check("model_sel", 32'(Sel), 32'(m_owner));
      check("model_timeout", 32'(Timeout), 32'(m_to));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) tick();
    chk_en = 1'b1;
    check("reset_grant", 32'(Grant), 32'h0);
    check("reset_dec_en", 32'(Dec_En), 32'h0);
    check("reset_sel", 32'(Sel), 32'h0);
    check("reset_timeout", 32'(Timeout), 32'h0);

    // No requests: stays idle.
    Reset = 1'b0; Enable = 1'b1; Req = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grant", 32'(Grant), 32'h0);
      check("idle_sel", 32'(Sel), 32'h0);
    end

    // Requesters 0 and 7 alternate with pointer wrap.
    Req = 8'h81;
    tick();
    check("r07_first_grant", 32'(Grant), 32'h80);
    check("r07_first_sel", 32'(Sel), 32'h0);
    Release = 1'b1;
    tick();
    check("r07_gap1", 32'(Grant), 32'h0);
    Release = 1'b0;
    tick();
    check("r07_second_grant", 32'(Grant), 32'h01);
    check("r07_second_sel", 32'(Sel), 32'h7);
    Release = 1'b1;
    tick();
    check("r07_gap2", 32'(Grant), 32'h0);
    check("r07_gap2_sel_held", 32'(Sel), 32'h7);
    Release = 1'b0;
    tick();
    check("r07_wrap_grant", 32'(Grant), 32'h80);
    Req = 8'h00;
    tick();

    // All eight requesting, release on every grant.
    Reset = 1'b1;
    tick();
    Reset = 1'b0; Req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_sel", 32'(Sel), 32'(i % 8));
      check("rr_grant", 32'(Grant), 32'(8'h80 >> (i % 8)));
      Release = 1'b1;
      tick();
      check("rr_gap", 32'(Grant), 32'h0);
      Release = 1'b0;
    end

    // Reset in the middle of a grant to requester 5.
    Req = 8'h04;
    tick();
    check("mid_sel5", 32'(Sel), 32'h5);
    check("mid_grant5", 32'(Grant), 32'h04);
    Reset = 1'b1;
    tick();
    check("mid_reset_grant", 32'(Grant), 32'h0);
    check("mid_reset_dec_en", 32'(Dec_En), 32'h0);
    Reset = 1'b0; Req = 8'hFF;
    tick();
    check("post_reset_sel", 32'(Sel), 32'h0);
    check("post_reset_grant", 32'(Grant), 32'h80);

    // Enable drop, then owner withdrawing its request.
    Enable = 1'b0;
    tick();
    check("en_drop_grant", 32'(Grant), 32'h0);
    Enable = 1'b1;
    tick();
    check("after_en_sel", 32'(Sel), 32'h1);
    Req = 8'hBF;
    tick();
    check("req_drop_grant", 32'(Grant), 32'h0);
    Req = 8'hFF;
    tick();
    check("req_drop_ptr_sel", 32'(Sel), 32'h2);
    Req = 8'h00;
    tick();

    // Long hold by requester 7.
    Req = 8'h01;
    tick();
    check("hold_start_grant", 32'(Grant), 32'h01);
    n = 1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (Grant == 8'h00) break;
      n++;
    end
`ifdef LINE_DECODER_ARB_TIMEOUT_EN
    check("hold_len", 32'(n), 32'(MH));
    check("timeout_pulse", 32'(Timeout), 32'h1);
    tick();
    check("timeout_single", 32'(Timeout), 32'h0);
`else
    check("hold_persist", 32'(n), 32'd121);
    check("no_timeout", 32'(Timeout), 32'h0);
`endif
    Req = 8'h00;
    repeat (3) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
